// File: rtl/tetris_pkg.sv
// Shared board geometry, writer FSM states and row access helper for the Tetris datapath.
package tetris_pkg;

  localparam int ROWS    = 20;
  localparam int COLS    = 10;
  localparam int BOARD_W = ROWS * COLS;
  localparam int ROW_IDX_W = 5;
  localparam int LINES_W   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MERGE = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } board_wr_state_t;

  // Row r lives at the top of the vector for r = 0; column 0 is the row slice MSB.
  function automatic logic [COLS-1:0] row_slice(input logic [BOARD_W-1:0] board,
                                                input logic [ROW_IDX_W-1:0] r);
    return board[BOARD_W-1-COLS*int'(r) -: COLS];
  endfunction

endpackage

// File: rtl/tetris_row_compactor.sv
// Combinational removal of one row: rows 1..row take rows 0..row-1, row 0 empties.
module tetris_row_compactor
  import tetris_pkg::*;
(
  input  logic [BOARD_W-1:0]   board_in,
  input  logic [ROW_IDX_W-1:0] row,
  output logic [BOARD_W-1:0]   board_out
);

  // Rows below the removed one are untouched; rows at or above it shift down by one.
  always_comb begin
    board_out = board_in;
    for (int i = 0; i < ROWS; i++) begin
      if (i <= int'(row)) begin
        if (i == 0) begin
          board_out[BOARD_W-1 -: COLS] = '0;
        end else begin
          board_out[BOARD_W-1-COLS*i -: COLS] = board_in[BOARD_W-1-COLS*(i-1) -: COLS];
        end
      end
    end
  end

endmodule

// File: rtl/tetris_board_writer.sv
// Board owner: merges locked pieces, compacts full rows one per clock, and
// publishes the working board to game_state only on a frame tick while idle.
//
// state | meaning
// IDLE  | accept a lock or a clear; commit work to game_state on frame_tick
// MERGE | OR latched piece into work, record overlap
// SCAN  | test row r bottom-up; remove full rows in place, else step upward
// DONE  | one-cycle done pulse, then back to IDLE
module tetris_board_writer
  import tetris_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               clear_req,
  input  logic               lock_valid,
  output logic               lock_ready,
  input  logic [BOARD_W-1:0] piece_layer,
  output logic [BOARD_W-1:0] game_state,
  output logic               busy,
  output logic               done,
  output logic [LINES_W-1:0] lines_cleared,
  output logic               overlap
);

  board_wr_state_t      state_q, state_d;
  logic [BOARD_W-1:0]   work_q, work_d;
  logic [BOARD_W-1:0]   piece_q, piece_d;
  logic [BOARD_W-1:0]   game_state_q, game_state_d;
  logic [ROW_IDX_W-1:0] r_q, r_d;
  logic [LINES_W-1:0]   lines_q, lines_d;
  logic                 overlap_q, overlap_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 lock_ready_q, lock_ready_d;

  logic [BOARD_W-1:0]   compacted;

  tetris_row_compactor u_compactor (
    .board_in  (work_q),
    .row       (r_q),
    .board_out (compacted)
  );

  // Next-state and datapath updates; status outputs are registered from the next state.
  always_comb begin
    state_d      = state_q;
    work_d       = work_q;
    piece_d      = piece_q;
    game_state_d = game_state_q;
    r_d          = r_q;
    lines_d      = lines_q;
    overlap_d    = overlap_q;

    case (state_q)
      IDLE: begin
        // Commit sees the board as it stands before this edge's clear or merge.
        if (frame_tick) begin
          game_state_d = work_q;
        end
        if (clear_req) begin
          work_d    = '0;
          overlap_d = 1'b0;
        end else if (lock_valid && lock_ready_q) begin
          piece_d   = piece_layer;
          lines_d   = '0;
          overlap_d = 1'b0;
          state_d   = MERGE;
        end
      end
      MERGE: begin
        work_d    = work_q | piece_q;
        overlap_d = |(work_q & piece_q);
        r_d       = ROW_IDX_W'(ROWS - 1);
        state_d   = SCAN;
      end
      SCAN: begin
        // A removed row pulls new content into r, so r is re-tested next cycle.
        if (&row_slice(work_q, r_q)) begin
          work_d  = compacted;
          lines_d = lines_q + LINES_W'(1);
        end else if (r_q == '0) begin
          state_d = DONE;
        end else begin
          r_d = r_q - ROW_IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d       = (state_d != IDLE);
    lock_ready_d = (state_d == IDLE);
    done_d       = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      work_q       <= '0;
      piece_q      <= '0;
      game_state_q <= '0;
      r_q          <= ROW_IDX_W'(ROWS - 1);
      lines_q      <= '0;
      overlap_q    <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      lock_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      work_q       <= work_d;
      piece_q      <= piece_d;
      game_state_q <= game_state_d;
      r_q          <= r_d;
      lines_q      <= lines_d;
      overlap_q    <= overlap_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      lock_ready_q <= lock_ready_d;
    end
  end

  assign game_state    = game_state_q;
  assign lines_cleared = lines_q;
  assign overlap       = overlap_q;
  assign done          = done_q;
  assign busy          = busy_q;
  assign lock_ready    = lock_ready_q;

endmodule
